// File: rtl/guess_pkg.sv
// ============================================================================
// Module   : guess_pkg
// Brief    : Shared digit codes, entry states and width helper for digit entry.
// Revision : 1.0
// ============================================================================
`default_nettype none

package guess_pkg;

    localparam int DIGIT_W = 3;

    localparam logic [DIGIT_W-1:0] c_dig_empty = 3'd0;
    localparam logic [DIGIT_W-1:0] c_dig_1     = 3'd1;
    localparam logic [DIGIT_W-1:0] c_dig_2     = 3'd2;
    localparam logic [DIGIT_W-1:0] c_dig_3     = 3'd3;
    localparam logic [DIGIT_W-1:0] c_dig_4     = 3'd4;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } entry_state_e;

    localparam logic [0:0] c_st_collect = 1'b0;
    localparam logic [0:0] c_st_hold    = 1'b1;

    // Width of a counter able to hold 0..max_digits inclusive.
    function automatic int len_width(input int max_digits);
        return $clog2(max_digits + 1);
    endfunction

    function automatic logic [DIGIT_W-1:0] key_code(input logic [3:0] onehot);
        logic [DIGIT_W-1:0] code;
        code = c_dig_empty;
        case (onehot)
            4'b0001: code = c_dig_1;
            4'b0010: code = c_dig_2;
            4'b0100: code = c_dig_3;
            4'b1000: code = c_dig_4;
            default: code = c_dig_empty;
        endcase
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/guess_digit_entry_key_sync_edge.sv
// ============================================================================
// Module   : key_sync_edge
// Brief    : 2-flop synchroniser followed by a registered rising-edge pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module key_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_press <= r_sync2 & ~r_prev;
        end
    end

    assign o_press = r_press;

endmodule

`default_nettype wire

// File: rtl/guess_digit_entry.sv
// ============================================================================
// Module   : guess_digit_entry
// Brief    : Collects key presses 1..4 into a number and offers it on enter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module guess_digit_entry #(
    parameter int MAX_DIGITS = 8,
    parameter int DIGIT_W    = 3
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           I1,
    input  logic                                           I2,
    input  logic                                           I3,
    input  logic                                           I4,
    input  logic                                           enter,
    output logic [MAX_DIGITS*DIGIT_W-1:0]                  num_digits,
    output logic [guess_pkg::len_width(MAX_DIGITS)-1:0]    num_len,
    output logic                                           num_valid,
    input  logic                                           num_ready,
    output logic [3:0]                                     nums,
    output logic                                           key_err,
    output logic                                           ovf
);

    import guess_pkg::*;

    localparam int LEN_W = len_width(MAX_DIGITS);
    localparam int BUF_W = MAX_DIGITS * DIGIT_W;

    logic [4:0]       w_raw;
    logic [4:0]       w_pulse;
    logic [3:0]       w_dig;
    logic             w_ent;
    logic             w_any;
    logic             w_multi;
    logic             w_full;
    logic [DIGIT_W-1:0] w_code;
    logic [BUF_W-1:0] w_buf_next;

    logic [0:0]       r_state;
    logic [BUF_W-1:0] r_buf;
    logic [LEN_W-1:0] r_count;
    logic [BUF_W-1:0] r_num_digits;
    logic [LEN_W-1:0] r_num_len;
    logic             r_num_valid;
    logic [3:0]       r_nums;
    logic             r_key_err;
    logic             r_ovf;

    assign w_raw = {enter, I4, I3, I2, I1};

    for (genvar i = 0; i < 5; i++) begin : g_key
        key_sync_edge u_sync (
            .clk     (clk),
            .rst     (reset),
            .i_key   (w_raw[i]),
            .o_press (w_pulse[i])
        );
    end

    assign w_dig   = w_pulse[3:0];
    assign w_ent   = w_pulse[4];
    assign w_any   = |w_dig;
    assign w_multi = (w_dig & (w_dig - 4'd1)) != 4'd0;
    assign w_full  = (r_count == LEN_W'(MAX_DIGITS));
    assign w_code  = DIGIT_W'(key_code(w_dig));

    always_comb begin
        w_buf_next = r_buf;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (r_count == LEN_W'(i)) begin
                w_buf_next[i*DIGIT_W +: DIGIT_W] = w_code;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_collect;
            r_buf        <= '0;
            r_count      <= '0;
            r_num_digits <= '0;
            r_num_len    <= '0;
            r_num_valid  <= 1'b0;
            r_nums       <= 4'd0;
            r_key_err    <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_key_err <= 1'b0;
            case (r_state)
                c_st_collect: begin
                    // Enter takes priority; any digit in the same cycle is lost.
                    if (w_ent) begin
                        r_key_err <= w_any;
                        if (r_count != '0) begin
                            r_num_digits <= r_buf;
                            r_num_len    <= r_count;
                            r_num_valid  <= 1'b1;
                            r_state      <= c_st_hold;
                        end
                    end else if (w_multi) begin
                        r_key_err <= 1'b1;
                    end else if (w_any) begin
                        if (w_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_buf   <= w_buf_next;
                            r_count <= r_count + LEN_W'(1);
                            r_nums  <= w_dig;
                        end
                    end
                end
                c_st_hold: begin
                    r_key_err <= w_any | w_ent;
                    if (num_ready) begin
                        r_num_valid <= 1'b0;
                        r_buf       <= '0;
                        r_count     <= '0;
                        r_ovf       <= 1'b0;
                        r_state     <= c_st_collect;
                    end
                end
                default: r_state <= c_st_collect;
            endcase
        end
    end

    assign num_digits = r_num_digits;
    assign num_len    = r_num_len;
    assign num_valid  = r_num_valid;
    assign nums       = r_nums;
    assign key_err    = r_key_err;
    assign ovf        = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_guess_digit_entry.sv
// ============================================================================
// Module   : tb_guess_digit_entry
// Brief    : Directed self-checking bench for guess_digit_entry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_guess_digit_entry;

    logic        clk = 1'b0;
    logic        reset;
    logic        I1, I2, I3, I4, enter;
    logic [23:0] num_digits;
    logic [3:0]  num_len;
    logic        num_valid;
    logic        num_ready;
    logic [3:0]  nums;
    logic        key_err;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    // Observed handshake, error-pulse and valid-cycle history.
    int          hs_cnt = 0;
    int          err_cnt = 0;
    int          vh_cnt = 0;
    logic [23:0] cap_d = '0;
    logic [3:0]  cap_l = '0;

    guess_digit_entry #(.MAX_DIGITS(8), .DIGIT_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .I1         (I1),
        .I2         (I2),
        .I3         (I3),
        .I4         (I4),
        .enter      (enter),
        .num_digits (num_digits),
        .num_len    (num_len),
        .num_valid  (num_valid),
        .num_ready  (num_ready),
        .nums       (nums),
        .key_err    (key_err),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            if (num_valid && num_ready) begin
                hs_cnt <= hs_cnt + 1;
                cap_d  <= num_digits;
                cap_l  <= num_len;
            end
            if (key_err)   err_cnt <= err_cnt + 1;
            if (num_valid) vh_cnt  <= vh_cnt + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a one-hot key pattern (bit4 = enter) high for `hold` cycles, then idle.
    task automatic key(input logic [4:0] k, input int hold);
        {enter, I4, I3, I2, I1} = k;
        step(hold);
        {enter, I4, I3, I2, I1} = 5'b0;
        step(6);
    endtask

    task automatic digit(input int d);
        key(5'b1 << (d - 1), 5);
    endtask

    int hs0, err0, vh0;

    initial begin
        reset = 1'b1;
        num_ready = 1'b0;
        {enter, I4, I3, I2, I1} = 5'b0;
        step(3);
        reset = 1'b0;
        step(1);
        chk("rst_digits", num_digits, 0);
        chk("rst_len",    num_len,    0);
        chk("rst_valid",  num_valid,  0);
        chk("rst_nums",   nums,       0);
        chk("rst_err",    key_err,    0);
        chk("rst_ovf",    ovf,        0);

        // 1,2,3,4 with ready high: valid lasts exactly one cycle.
        num_ready = 1'b1;
        vh0 = vh_cnt;
        digit(1); digit(2); digit(3); digit(4);
        chk("t1_nums", nums, 4'b1000);
        key(5'b10000, 5);
        chk("t1_hs",     hs_cnt, 1);
        chk("t1_digits", cap_d, 24'h0008D1);
        chk("t1_len",    cap_l, 4);
        chk("t1_vcyc",   vh_cnt - vh0, 1);
        chk("t1_valid0", num_valid, 0);

        // 1,4,3,2,1 held in HOLD while ready is low.
        num_ready = 1'b0;
        digit(1); digit(4); digit(3); digit(2); digit(1);
        key(5'b10000, 5);
        chk("t2_valid",  num_valid, 1);
        chk("t2_digits", num_digits, 24'h0014E1);
        chk("t2_len",    num_len, 5);
        step(10);
        chk("t2_hold_digits", num_digits, 24'h0014E1);
        chk("t2_hold_len",    num_len, 5);
        chk("t2_hold_valid",  num_valid, 1);
        num_ready = 1'b1;
        step(1);
        chk("t2_valid_drop", num_valid, 0);
        chk("t2_hs",         hs_cnt, 2);
        chk("t2_cap",        cap_d, 24'h0014E1);

        // Nine presses of I2: ninth dropped, overflow sticky until handshake.
        num_ready = 1'b0;
        for (int i = 0; i < 8; i++) digit(2);
        chk("t3_ovf_pre", ovf, 0);
        digit(2);
        chk("t3_ovf", ovf, 1);
        key(5'b10000, 5);
        chk("t3_digits", num_digits, 24'h492492);
        chk("t3_len",    num_len, 8);
        chk("t3_ovf_hold", ovf, 1);
        num_ready = 1'b1;
        step(1);
        chk("t3_ovf_clr",  ovf, 0);
        chk("t3_valid0",   num_valid, 0);

        // Simultaneous I1+I3: dropped with one error pulse, then single digit 4.
        err0 = err_cnt;
        key(5'b00101, 5);
        chk("t4_err",  err_cnt - err0, 1);
        chk("t4_nums", nums, 4'b0010);
        digit(4);
        hs0 = hs_cnt;
        key(5'b10000, 5);
        chk("t4_hs",     hs_cnt - hs0, 1);
        chk("t4_digits", cap_d, 24'h000004);
        chk("t4_len",    cap_l, 1);

        // Enter on empty buffer is ignored; held key yields a single digit.
        hs0 = hs_cnt; err0 = err_cnt; vh0 = vh_cnt;
        key(5'b10000, 5);
        chk("t5_empty_vcyc", vh_cnt - vh0, 0);
        chk("t5_empty_err",  err_cnt - err0, 0);
        key(5'b00001, 20);
        key(5'b10000, 5);
        chk("t5_hs",     hs_cnt - hs0, 1);
        chk("t5_len",    cap_l, 1);
        chk("t5_digits", cap_d, 24'h000001);

        // Press during HOLD, then reset while holding.
        num_ready = 1'b0;
        digit(1); digit(2);
        key(5'b10000, 5);
        chk("t6_valid", num_valid, 1);
        err0 = err_cnt;
        digit(3);
        chk("t6_err",    err_cnt - err0, 1);
        chk("t6_digits", num_digits, 24'h000011);
        reset = 1'b1;
        step(1);
        chk("t6_rst_valid", num_valid, 0);
        reset = 1'b0;
        step(1);
        chk("t6_rst_digits", num_digits, 0);
        chk("t6_rst_len",    num_len, 0);
        chk("t6_rst_nums",   nums, 0);
        chk("t6_rst_ovf",    ovf, 0);
        num_ready = 1'b1;
        hs0 = hs_cnt;
        digit(4);
        key(5'b10000, 5);
        chk("t6_collect_hs",  hs_cnt - hs0, 1);
        chk("t6_collect_len", cap_l, 1);
        chk("t6_collect_dig", cap_d, 24'h000004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
